// File: rtl/cmd_scheduler_pkg.sv
// caotai_cmd_pkg: command codes, entry layout, FSM encoding and status bit positions
package caotai_cmd_pkg;
    localparam int WID_8 = 8;
    localparam int WID_16 = 16;
    localparam int CMD_W = WID_8 + 4 * WID_16;
    localparam logic [7:0] CMD_MOVE = 8'h01;
    localparam logic [7:0] CMD_AUX = 8'h02;
    localparam logic [7:0] CMD_DELAY = 8'h03;
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_FETCH = 4'd1;
    localparam logic [3:0] S_ISSUE_MOT = 4'd2;
    localparam logic [3:0] S_WAIT_MOT = 4'd3;
    localparam logic [3:0] S_ISSUE_AUX = 4'd4;
    localparam logic [3:0] S_WAIT_AUX = 4'd5;
    localparam logic [3:0] S_DELAY = 4'd6;
    localparam int ST_OVF = 19;
    localparam int ST_DONE = 18;
    localparam int ST_BUSY = 17;
    localparam int ST_UNK = 16;
    typedef struct packed {
        logic [WID_8-1:0] typ;
        logic [WID_16-1:0] d3;
        logic [WID_16-1:0] d2;
        logic [WID_16-1:0] d1;
        logic [WID_16-1:0] d0;
    } cmd_t;
endpackage

// File: rtl/cmd_scheduler_if.sv
// cmd_scheduler_if: decoder input, executor handshakes and status readback of the command scheduler
interface cmd_scheduler_if;
    import caotai_cmd_pkg::*;
    logic cmd_in_vld;
    logic [WID_8-1:0] cmd_in_type;
    logic [WID_16-1:0] cmd_in_data0, cmd_in_data1, cmd_in_data2, cmd_in_data3;
    logic cmd_end_flag;
    logic [WID_16-1:0] cmd_err_num;
    logic abort;
    logic [WID_8-1:0] exe_type;
    logic [WID_16-1:0] exe_data0, exe_data1, exe_data2, exe_data3;
    logic mot_vld, mot_rdy, mot_done;
    logic aux_vld, aux_rdy, aux_done;
    logic [31:0] status;
    modport master (
        output cmd_in_vld, cmd_in_type, cmd_in_data0, cmd_in_data1, cmd_in_data2, cmd_in_data3,
        output cmd_end_flag, cmd_err_num, abort, mot_rdy, mot_done, aux_rdy, aux_done,
        input exe_type, exe_data0, exe_data1, exe_data2, exe_data3, mot_vld, aux_vld, status
    );
    modport slave (
        input cmd_in_vld, cmd_in_type, cmd_in_data0, cmd_in_data1, cmd_in_data2, cmd_in_data3,
        input cmd_end_flag, cmd_err_num, abort, mot_rdy, mot_done, aux_rdy, aux_done,
        output exe_type, exe_data0, exe_data1, exe_data2, exe_data3, mot_vld, aux_vld, status
    );
endinterface

// File: rtl/cmd_scheduler_fifo.sv
// cmd_fifo: synchronous FIFO with registered read data, occupancy count and synchronous flush
module cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int W = 72
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   wr_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   rd_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    // Callers only write when not full (or reading) and only read when not empty.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
            rdata_q <= '0;
        end else begin
            if (wr_i) wp_q <= wp_q + 1'b1;
            if (rd_i) begin
                rp_q <= rp_q + 1'b1;
                rdata_q <= mem_q[rp_q];
            end
            cnt_q <= cnt_q + CW'(wr_i) - CW'(rd_i);
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr_i) mem_q[wp_q] <= wdata_i;
    end
    assign rdata_o = rdata_q;
    assign count_o = cnt_q;
endmodule

// File: rtl/cmd_scheduler.sv
// cmd_scheduler: buffers decoded commands and dispatches them in order, one in flight, to the
// motion or aux executor; delays run internally and a registered status word is exported.
module cmd_scheduler
    import caotai_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_PER_MS = 48000
) (
    input  logic           clk_48m,
    input  logic           rst_48m_n,
    cmd_scheduler_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(CLK_PER_MS + 1);
    logic [3:0] state_q, state_d;
    logic [15:0] ms_q, ms_d;
    logic [SW-1:0] sub_q, sub_d;
    logic ovf_q, unk_q, end_q;
    logic [31:0] status_q;
    cmd_t exe_q, rd_cmd;
    logic [CMD_W-1:0] rd_data;
    logic [CW-1:0] count;
    logic empty, rd_en, wr_ok, wrap;

    assign empty = count == '0;
    assign rd_en = state_q == S_IDLE && !empty && !bus.abort;
    assign wr_ok = bus.cmd_in_vld && !bus.abort && (count < CW'(FIFO_DEPTH) || rd_en);
    assign rd_cmd = cmd_t'(rd_data);
    assign wrap = sub_q == SW'(CLK_PER_MS - 1);

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
        .clk_i(clk_48m),
        .rst_ni(rst_48m_n),
        .flush_i(bus.abort),
        .wr_i(wr_ok),
        .wdata_i({bus.cmd_in_type, bus.cmd_in_data3, bus.cmd_in_data2, bus.cmd_in_data1, bus.cmd_in_data0}),
        .rd_i(rd_en),
        .rdata_o(rd_data),
        .count_o(count)
    );

    always_comb begin
        state_d = state_q;
        ms_d = ms_q;
        sub_d = sub_q;
        case (state_q)
            S_IDLE: state_d = empty ? S_IDLE : S_FETCH;
            S_FETCH: begin
                state_d = rd_cmd.typ == CMD_MOVE ? S_ISSUE_MOT :
                          rd_cmd.typ == CMD_AUX ? S_ISSUE_AUX :
                          rd_cmd.typ == CMD_DELAY ? S_DELAY : S_IDLE;
                ms_d = rd_cmd.d0;
                sub_d = '0;
            end
            S_ISSUE_MOT: state_d = bus.mot_rdy ? S_WAIT_MOT : state_q;
            S_WAIT_MOT: state_d = bus.mot_done ? S_IDLE : state_q;
            S_ISSUE_AUX: state_d = bus.aux_rdy ? S_WAIT_AUX : state_q;
            S_WAIT_AUX: state_d = bus.aux_done ? S_IDLE : state_q;
            S_DELAY: begin
                // ms reaching zero ends the delay, so a zero-length delay costs one cycle
                state_d = ms_q == '0 ? S_IDLE : state_q;
                sub_d = wrap ? '0 : sub_q + 1'b1;
                ms_d = ms_q != '0 && wrap ? ms_q - 1'b1 : ms_q;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk_48m) begin
        if (!rst_48m_n) begin
            state_q <= S_IDLE;
            ms_q <= '0;
            sub_q <= '0;
            ovf_q <= 1'b0;
            unk_q <= 1'b0;
            end_q <= 1'b0;
            exe_q <= '0;
            status_q <= '0;
        end else begin
            state_q <= state_d;
            ms_q <= ms_d;
            sub_q <= sub_d;
            ovf_q <= !bus.abort && (ovf_q || (bus.cmd_in_vld && !wr_ok));
            unk_q <= !bus.abort && (unk_q || (state_q == S_FETCH && state_d == S_IDLE));
            end_q <= !bus.abort && (bus.cmd_end_flag || (end_q && !wr_ok));
            if (state_q == S_FETCH) exe_q <= rd_cmd;
            status_q <= {8'(count), state_q, ovf_q, end_q && empty && state_q == S_IDLE,
                         state_q != S_IDLE || !empty, unk_q, bus.cmd_err_num};
        end
    end

    assign bus.exe_type = exe_q.typ;
    assign bus.exe_data0 = exe_q.d0;
    assign bus.exe_data1 = exe_q.d1;
    assign bus.exe_data2 = exe_q.d2;
    assign bus.exe_data3 = exe_q.d3;
    assign bus.mot_vld = state_q == S_ISSUE_MOT;
    assign bus.aux_vld = state_q == S_ISSUE_AUX;
    assign bus.status = status_q;
endmodule

// File: tb/tb_cmd_scheduler.sv
// tb_cmd_scheduler: directed stimulus with an expected-dispatch queue checked by an output monitor
module tb_cmd_scheduler;
    import caotai_cmd_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [72:0] exp_q[$];

    cmd_scheduler_if bus_if();
    cmd_scheduler #(.FIFO_DEPTH(16), .CLK_PER_MS(10)) dut (
        .clk_48m(clk),
        .rst_48m_n(rst_n),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Every handshake must match the oldest expected dispatch: {is_aux, type, d3, d2, d1, d0}.
    always @(negedge clk) begin : mon
        logic [72:0] got, e;
        if (rst_n && ((bus_if.mot_vld && bus_if.mot_rdy) || (bus_if.aux_vld && bus_if.aux_rdy))) begin
            got = {bus_if.aux_vld, bus_if.exe_type, bus_if.exe_data3, bus_if.exe_data2, bus_if.exe_data1, bus_if.exe_data0};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dispatch: unexpected %h", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL dispatch: got %h expected %h", got, e);
                end
            end
        end
    end

    function automatic logic [71:0] mk(input logic [7:0] t, input logic [15:0] d0);
        return {t, {t, 8'h3C}, d0 ^ 16'h5A5A, ~d0, d0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_rng(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic expect_cmd(input bit aux, input logic [7:0] t, input logic [15:0] d0);
        exp_q.push_back({aux, mk(t, d0)});
    endtask

    task automatic push(input logic [7:0] t, input logic [15:0] d0);
        bus_if.cmd_in_vld = 1'b1;
        {bus_if.cmd_in_type, bus_if.cmd_in_data3, bus_if.cmd_in_data2, bus_if.cmd_in_data1, bus_if.cmd_in_data0} = mk(t, d0);
        tick(1);
        bus_if.cmd_in_vld = 1'b0;
    endtask

    task automatic wait_vld(input string name, output bit aux);
        int n = 0;
        while (!bus_if.mot_vld && !bus_if.aux_vld && n < 40) begin
            tick(1);
            n++;
        end
        check_rng(name, n, 0, 39);
        aux = bus_if.aux_vld;
    endtask

    task automatic wait_state(input string name, input logic [3:0] s);
        int n = 0;
        while (bus_if.status[23:20] != s && n < 40) begin
            tick(1);
            n++;
        end
        check_rng(name, n, 0, 39);
    endtask

    task automatic complete(input string name);
        bit aux;
        wait_vld(name, aux);
        tick(1);
        if (aux) bus_if.aux_done = 1'b1;
        else bus_if.mot_done = 1'b1;
        tick(1);
        bus_if.aux_done = 1'b0;
        bus_if.mot_done = 1'b0;
    endtask

    initial begin
        bit aux;
        bit seen;
        int n;
        bus_if.cmd_in_vld = 0;
        bus_if.cmd_in_type = 0;
        bus_if.cmd_in_data0 = 0;
        bus_if.cmd_in_data1 = 0;
        bus_if.cmd_in_data2 = 0;
        bus_if.cmd_in_data3 = 0;
        bus_if.cmd_end_flag = 0;
        bus_if.cmd_err_num = 0;
        bus_if.abort = 0;
        bus_if.mot_rdy = 0;
        bus_if.mot_done = 0;
        bus_if.aux_rdy = 0;
        bus_if.aux_done = 0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_status", bus_if.status, 32'h0);
        check("rst_vld", {bus_if.mot_vld, bus_if.aux_vld}, 0);
        check("rst_exe", {bus_if.exe_type, bus_if.exe_data0}, 0);
        bus_if.cmd_err_num = 16'h0005;
        tick(2);
        check("err_num", bus_if.status, 32'h0000_0005);

        // MOVE then AUX: aux must wait for mot_done
        bus_if.mot_rdy = 1;
        bus_if.aux_rdy = 1;
        expect_cmd(0, CMD_MOVE, 16'h0064);
        expect_cmd(1, CMD_AUX, 16'h00FF);
        push(CMD_MOVE, 16'h0064);
        push(CMD_AUX, 16'h00FF);
        n = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            n += int'(bus_if.mot_vld);
            seen |= bus_if.aux_vld;
            tick(1);
        end
        check("t1_mot_vld_cycles", n, 1);
        check("t1_aux_early", seen, 0);
        bus_if.mot_done = 1;
        tick(1);
        bus_if.mot_done = 0;
        complete("t1_aux");
        tick(3);
        check("t1_idle", {bus_if.status[23:20], bus_if.status[ST_BUSY]}, 0);

        // stalled motion executor
        bus_if.mot_rdy = 0;
        expect_cmd(0, CMD_MOVE, 16'h1234);
        push(CMD_MOVE, 16'h1234);
        wait_vld("t2_vld", aux);
        seen = 1;
        for (int i = 0; i < 20; i++) begin
            seen &= bus_if.mot_vld && ({bus_if.exe_type, bus_if.exe_data3, bus_if.exe_data2, bus_if.exe_data1, bus_if.exe_data0} == mk(CMD_MOVE, 16'h1234));
            tick(1);
        end
        check("t2_stable", seen, 1);
        check("t2_state", bus_if.status[23:20], S_ISSUE_MOT);
        check("t2_busy", bus_if.status[ST_BUSY], 1);
        bus_if.mot_rdy = 1;
        complete("t2_done");

        // overflow: block the FSM, then 17 writes into a 16-deep FIFO
        bus_if.mot_rdy = 0;
        expect_cmd(0, CMD_MOVE, 16'h00B0);
        push(CMD_MOVE, 16'h00B0);
        wait_vld("t3_block", aux);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expect_cmd(1, CMD_AUX, 16'(i));
            push(CMD_AUX, 16'(i));
        end
        tick(2);
        check("t3_count", bus_if.status[31:24], 8'h10);
        check("t3_ovf", bus_if.status[ST_OVF], 1);
        bus_if.mot_rdy = 1;
        for (int i = 0; i < 17; i++) complete("t3_drain");
        check("t3_sb_empty", exp_q.size(), 0);

        // delays with CLK_PER_MS=10
        push(CMD_DELAY, 16'd3);
        wait_state("t4_enter3", S_DELAY);
        n = 0;
        while (bus_if.status[23:20] == S_DELAY && n < 60) begin
            n++;
            tick(1);
        end
        check_rng("t4_delay3_len", n, 30, 32);
        push(CMD_DELAY, 16'd0);
        wait_state("t4_enter0", S_DELAY);
        n = 0;
        while (bus_if.status[23:20] == S_DELAY && n < 60) begin
            n++;
            tick(1);
        end
        check_rng("t4_delay0_len", n, 1, 2);

        // unknown type and program end
        push(8'h7E, 16'h0042);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            seen |= bus_if.mot_vld | bus_if.aux_vld;
            tick(1);
        end
        check("t5_no_vld", seen, 0);
        check("t5_unk", bus_if.status[ST_UNK], 1);
        check("t5_not_done", bus_if.status[ST_DONE], 0);
        bus_if.cmd_end_flag = 1;
        tick(1);
        bus_if.cmd_end_flag = 0;
        tick(2);
        check("t5_prog_done", bus_if.status[ST_DONE], 1);
        push(CMD_DELAY, 16'd0);
        tick(1);
        check("t5_done_cleared", bus_if.status[ST_DONE], 0);
        tick(4);

        // abort in WAIT_MOT with five queued, plus a write in the abort cycle
        expect_cmd(0, CMD_MOVE, 16'h00A0);
        for (int i = 0; i < 6; i++) push(CMD_MOVE, 16'h00A0 + 16'(i));
        tick(2);
        check("t6_state", bus_if.status[23:20], S_WAIT_MOT);
        check("t6_count", bus_if.status[31:24], 8'd5);
        bus_if.abort = 1;
        bus_if.cmd_in_vld = 1;
        {bus_if.cmd_in_type, bus_if.cmd_in_data3, bus_if.cmd_in_data2, bus_if.cmd_in_data1, bus_if.cmd_in_data0} = mk(CMD_MOVE, 16'h0BAD);
        tick(1);
        bus_if.abort = 0;
        bus_if.cmd_in_vld = 0;
        check("t6_vld_off", {bus_if.mot_vld, bus_if.aux_vld}, 0);
        tick(1);
        check("t6_status", bus_if.status, 32'h0000_0005);
        bus_if.mot_done = 1;
        tick(1);
        bus_if.mot_done = 0;
        tick(3);
        check("t6_late_done", bus_if.status, 32'h0000_0005);

        // reset in the middle of a delay
        push(CMD_DELAY, 16'd5);
        wait_state("t7_enter", S_DELAY);
        rst_n = 0;
        tick(1);
        check("t7_status", bus_if.status, 32'h0);
        check("t7_exe", {bus_if.exe_type, bus_if.exe_data0}, 0);
        check("t7_vld", {bus_if.mot_vld, bus_if.aux_vld}, 0);
        rst_n = 1;
        tick(2);
        check("t7_idle", bus_if.status, 32'h0000_0005);
        tick(2);
        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
